core_sequencer: RTL and testbench

Top-level control FSM of the multi-cycle core. It sequences the five pipeline-less stages (fetch, decode, exec, mem, write) with one-cycle enable pulses and waits for each stage's done pulse before starting the next. It skips mem for non-memory instructions and stops on halt or on a stalled stage. It also keeps cycle and retired-instruction counters for the debug/UART monitor.

---
 rtl/core_sequencer_pkg.sv | 25 ++
 rtl/core_sequencer_watchdog.sv | 36 +++
 rtl/core_sequencer.sv | 175 +++++++++++++++++
 tb/tb_core_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_sequencer_pkg.sv
// Shared stage codes, FSM state encoding and helpers for the core sequencer.
package core_sequencer_pkg;

    localparam int unsigned NUM_STAGES = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HALT,
        ST_ERROR
    } seq_state_e;

    typedef enum logic [2:0] {
        STG_FETCH  = 3'd0,
        STG_DECODE = 3'd1,
        STG_EXEC   = 3'd2,
        STG_MEM    = 3'd3,
        STG_WRITE  = 3'd4
    } stage_e;

    function automatic logic [NUM_STAGES-1:0] stage_onehot(input stage_e stg);
        return NUM_STAGES'(1) << stg;
    endfunction

endpackage

// File: rtl/core_sequencer_watchdog.sv
// Per-stage watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the TIMEOUT-th count is reached.
module stage_watchdog #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned CW = $clog2(TIMEOUT) + 1;

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != '1)) begin
            count_d = count_q + CW'(1);
        end
    end

    assign expire = en && (count_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/core_sequencer.sv
// Top-level control FSM of the multi-cycle core: issues one-cycle stage
// enables, waits for each done, and keeps cycle / retired-instruction counters.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             run,
    output logic             fetch_enable,
    output logic             decode_enable,
    output logic             exec_enable,
    output logic             mem_enable,
    output logic             write_enable,
    input  logic             fetch_done,
    input  logic             decode_done,
    input  logic             exec_done,
    input  logic             mem_done,
    input  logic             write_done,
    input  logic             mem_skip,
    input  logic             halt_req,
    output logic             halted,
    output logic             error,
    output logic [2:0]       err_stage,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret
);

    seq_state_e              state_q, state_d;
    stage_e                  cur_q, cur_d;
    logic [NUM_STAGES-1:0]   en_q, en_d;
    logic                    skip_q, skip_d;
    logic                    hlt_q, hlt_d;
    logic                    halted_q, halted_d;
    logic                    error_q, error_d;
    logic [2:0]              err_stage_q, err_stage_d;
    logic [CNT_W-1:0]        cycle_q, cycle_d;
    logic [CNT_W-1:0]        instret_q, instret_d;
    logic                    done_cur;
    logic                    wd_clr, wd_en, wd_expire;

    always_comb begin
        case (cur_q)
            STG_FETCH:  done_cur = fetch_done;
            STG_DECODE: done_cur = decode_done;
            STG_EXEC:   done_cur = exec_done;
            STG_MEM:    done_cur = mem_done;
            STG_WRITE:  done_cur = write_done;
            default:    done_cur = 1'b0;
        endcase
    end

    stage_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rstn   (rstn),
        .clr    (wd_clr),
        .en     (wd_en),
        .expire (wd_expire)
    );

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        en_d        = '0;
        skip_d      = skip_q;
        hlt_d       = hlt_q;
        halted_d    = halted_q;
        error_d     = error_q;
        err_stage_d = err_stage_q;
        cycle_d     = cycle_q;
        instret_d   = instret_q;
        wd_clr      = 1'b0;
        wd_en       = (state_q == ST_WAIT);

        if (state_q == ST_WAIT) begin
            cycle_d = cycle_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_WAIT;
                    cur_d   = STG_FETCH;
                    en_d    = stage_onehot(STG_FETCH);
                    wd_clr  = 1'b1;
                end
            end
            ST_WAIT: begin
                // A done on the current stage beats a same-cycle watchdog expiry.
                if (done_cur) begin
                    wd_clr = 1'b1;
                    case (cur_q)
                        STG_FETCH: begin
                            cur_d = STG_DECODE;
                            en_d  = stage_onehot(STG_DECODE);
                        end
                        STG_DECODE: begin
                            skip_d = mem_skip;
                            hlt_d  = halt_req;
                            cur_d  = STG_EXEC;
                            en_d   = stage_onehot(STG_EXEC);
                        end
                        STG_EXEC: begin
                            cur_d = skip_q ? STG_WRITE : STG_MEM;
                            en_d  = stage_onehot(skip_q ? STG_WRITE : STG_MEM);
                        end
                        STG_MEM: begin
                            cur_d = STG_WRITE;
                            en_d  = stage_onehot(STG_WRITE);
                        end
                        default: begin
                            instret_d = instret_q + CNT_W'(1);
                            if (hlt_q) begin
                                state_d  = ST_HALT;
                                halted_d = 1'b1;
                            end else if (run) begin
                                cur_d = STG_FETCH;
                                en_d  = stage_onehot(STG_FETCH);
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                    endcase
                end else if (wd_expire) begin
                    state_d     = ST_ERROR;
                    error_d     = 1'b1;
                    err_stage_d = cur_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            cur_q       <= STG_FETCH;
            en_q        <= '0;
            skip_q      <= 1'b0;
            hlt_q       <= 1'b0;
            halted_q    <= 1'b0;
            error_q     <= 1'b0;
            err_stage_q <= '0;
            cycle_q     <= '0;
            instret_q   <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            en_q        <= en_d;
            skip_q      <= skip_d;
            hlt_q       <= hlt_d;
            halted_q    <= halted_d;
            error_q     <= error_d;
            err_stage_q <= err_stage_d;
            cycle_q     <= cycle_d;
            instret_q   <= instret_d;
        end
    end

    assign fetch_enable  = en_q[STG_FETCH];
    assign decode_enable = en_q[STG_DECODE];
    assign exec_enable   = en_q[STG_EXEC];
    assign mem_enable    = en_q[STG_MEM];
    assign write_enable  = en_q[STG_WRITE];
    assign halted        = halted_q;
    assign error         = error_q;
    assign err_stage     = err_stage_q;
    assign cycle_count   = cycle_q;
    assign instret       = instret_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: stimulus queues expected enable pulses
// and status values per cycle; a monitor compares them against the DUT.
module tb_core_sequencer;

    logic        clk;
    logic        rstn;
    logic        run;
    logic        fetch_enable, decode_enable, exec_enable, mem_enable, write_enable;
    logic        fetch_done, decode_done, exec_done, mem_done, write_done;
    logic        mem_skip, halt_req;
    logic        halted, error;
    logic [2:0]  err_stage;
    logic [31:0] cycle_count, instret;

    logic [4:0]  done_r = '0;
    logic [4:0]  spur   = '0;
    logic        skip_r = 1'b0;
    logic        halt_r = 1'b0;
    int          cnt[5] = '{default: 0};
    int          dly[5] = '{1, 1, 1, 1, 1};
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    typedef struct { int stg; int cyc; } en_exp_t;
    typedef struct { bit skip; bit halt; } cfg_t;
    typedef enum int { F_HALTED, F_ERROR, F_ERRSTG, F_CYCLES, F_INSTRET, F_ENQ, F_ENABLES } fld_e;
    typedef struct { int cyc; fld_e fld; longint exp; string name; } st_exp_t;

    en_exp_t eq[$];
    st_exp_t sq[$];
    cfg_t    cfgq[$];

    core_sequencer #(
        .TIMEOUT (16),
        .CNT_W   (32)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .run           (run),
        .fetch_enable  (fetch_enable),
        .decode_enable (decode_enable),
        .exec_enable   (exec_enable),
        .mem_enable    (mem_enable),
        .write_enable  (write_enable),
        .fetch_done    (fetch_done),
        .decode_done   (decode_done),
        .exec_done     (exec_done),
        .mem_done      (mem_done),
        .write_done    (write_done),
        .mem_skip      (mem_skip),
        .halt_req      (halt_req),
        .halted        (halted),
        .error         (error),
        .err_stage     (err_stage),
        .cycle_count   (cycle_count),
        .instret       (instret)
    );

    assign fetch_done  = done_r[0] | spur[0];
    assign decode_done = done_r[1] | spur[1];
    assign exec_done   = done_r[2] | spur[2];
    assign mem_done    = done_r[3] | spur[3];
    assign write_done  = done_r[4] | spur[4];
    assign mem_skip    = skip_r;
    assign halt_req    = halt_r;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stage model: done arrives dly[s] cycles after the enable; dly 0 = never.
    always @(negedge clk) begin
        logic [4:0] en;
        cfg_t       c;
        en = {write_enable, mem_enable, exec_enable, decode_enable, fetch_enable};
        for (int s = 0; s < 5; s++) begin
            done_r[s] = 1'b0;
            if (cnt[s] > 0) begin
                cnt[s] = cnt[s] - 1;
                if (cnt[s] == 0) done_r[s] = 1'b1;
            end
            if (en[s] && dly[s] > 0) cnt[s] = dly[s];
        end
        skip_r = 1'b0;
        halt_r = 1'b0;
        if (done_r[1] && cfgq.size() > 0) begin
            c = cfgq.pop_front();
            skip_r = c.skip;
            halt_r = c.halt;
        end
    end

    function automatic longint field_val(input fld_e f);
        case (f)
            F_HALTED:  return longint'(halted);
            F_ERROR:   return longint'(error);
            F_ERRSTG:  return longint'(err_stage);
            F_CYCLES:  return longint'(cycle_count);
            F_INSTRET: return longint'(instret);
            F_ENQ:     return longint'(eq.size());
            default:   return longint'({write_enable, mem_enable, exec_enable, decode_enable, fetch_enable});
        endcase
    endfunction

    always @(negedge clk) begin
        logic [4:0] en;
        int         stg;
        en_exp_t    e;
        st_exp_t    s;
        longint     act;
        en = {write_enable, mem_enable, exec_enable, decode_enable, fetch_enable};
        while (eq.size() > 0 && eq[0].cyc < cyc) begin
            e = eq.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL missing_enable stage=%0d want_cycle=%0d now=%0d", e.stg, e.cyc, cyc);
        end
        if (en != '0) begin
            n_checks++;
            if (!$onehot(en)) begin
                n_fail++;
                $display("FAIL enable_onehot cycle=%0d got=%b want=one-hot", cyc, en);
            end
            stg = 0;
            for (int i = 4; i >= 0; i--) if (en[i]) stg = i;
            n_checks++;
            if (eq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_enable cycle=%0d got_stage=%0d want=none", cyc, stg);
            end else begin
                e = eq.pop_front();
                if (e.stg != stg || e.cyc != cyc) begin
                    n_fail++;
                    $display("FAIL enable_order got_stage=%0d got_cycle=%0d want_stage=%0d want_cycle=%0d",
                             stg, cyc, e.stg, e.cyc);
                end
            end
        end
        while (sq.size() > 0 && sq[0].cyc <= cyc) begin
            s = sq.pop_front();
            n_checks++;
            act = field_val(s.fld);
            if (s.cyc != cyc || act != s.exp) begin
                n_fail++;
                $display("FAIL %s cycle=%0d got=%0d want=%0d (want_cycle=%0d)", s.name, cyc, act, s.exp, s.cyc);
            end
        end
    end

    task automatic exp_en(input int stg, input int at);
        en_exp_t e;
        e.stg = stg;
        e.cyc = at;
        eq.push_back(e);
    endtask

    task automatic exp_st(input int at, input fld_e f, input longint v, input string nm);
        st_exp_t s;
        s.cyc = at;
        s.fld = f;
        s.exp = v;
        s.name = nm;
        sq.push_back(s);
    endtask

    task automatic push_cfg(input bit skip, input bit halt);
        cfg_t c;
        c.skip = skip;
        c.halt = halt;
        cfgq.push_back(c);
    endtask

    task automatic push_instr(input int base, input bit skip);
        exp_en(0, base);
        exp_en(1, base + 2);
        exp_en(2, base + 4);
        if (skip) begin
            exp_en(4, base + 6);
        end else begin
            exp_en(3, base + 6);
            exp_en(4, base + 8);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic do_reset();
        run  = 1'b0;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout cycle=%0d", cyc);
        $fatal(1, "bench time limit");
    end

    initial begin
        int c;
        rstn = 1'b0;
        run  = 1'b0;

        // Reset with stray done pulses, then mem / mem_skip instructions, spurious dones, run drop.
        repeat (2) @(negedge clk);
        spur = 5'b00011;
        @(negedge clk);
        spur = '0;
        @(negedge clk);
        rstn = 1'b1;
        c = cyc;
        exp_st(c + 1, F_INSTRET, 0, "reset_instret");
        exp_st(c + 1, F_CYCLES, 0, "reset_cycles");
        exp_st(c + 1, F_HALTED, 0, "reset_halted");
        exp_st(c + 1, F_ERROR, 0, "reset_error");
        exp_st(c + 1, F_ERRSTG, 0, "reset_err_stage");
        exp_st(c + 1, F_ENABLES, 0, "reset_enables");
        wait_cyc(c + 2);
        c = cyc;
        run = 1'b1;
        push_cfg(1'b0, 1'b0);
        push_cfg(1'b1, 1'b0);
        push_instr(c + 1, 1'b0);
        push_instr(c + 11, 1'b1);
        exp_st(c + 11, F_INSTRET, 1, "instret_after_first");
        exp_st(c + 11, F_CYCLES, 10, "cycles_after_first");
        exp_st(c + 19, F_INSTRET, 2, "instret_after_skip");
        exp_st(c + 19, F_CYCLES, 18, "cycles_after_skip");
        exp_st(c + 30, F_CYCLES, 18, "cycles_frozen_idle");
        exp_st(c + 30, F_INSTRET, 2, "instret_idle_spurious");
        exp_st(c + 30, F_ENQ, 0, "scoreboard_drained_a");
        wait_cyc(c + 12);
        run = 1'b0;
        wait_cyc(c + 15);
        spur = 5'b00001;
        wait_cyc(c + 16);
        spur = '0;
        wait_cyc(c + 22);
        spur = 5'b10000;
        wait_cyc(c + 23);
        spur = '0;
        wait_cyc(c + 31);

        // Halting instruction: completes, then no enables although run stays high.
        do_reset();
        c = cyc;
        run = 1'b1;
        push_cfg(1'b0, 1'b1);
        push_instr(c + 1, 1'b0);
        exp_st(c + 10, F_HALTED, 0, "halted_before_write_done");
        exp_st(c + 11, F_HALTED, 1, "halted_after_write_done");
        exp_st(c + 11, F_INSTRET, 1, "halt_instret");
        exp_st(c + 11, F_CYCLES, 10, "halt_cycles");
        exp_st(c + 30, F_HALTED, 1, "halted_sticky");
        exp_st(c + 30, F_ERROR, 0, "halt_no_error");
        exp_st(c + 30, F_ENQ, 0, "scoreboard_drained_b");
        wait_cyc(c + 31);

        // Exec done lands in the same cycle the watchdog would expire: done wins.
        do_reset();
        dly[2] = 15;
        c = cyc;
        run = 1'b1;
        push_cfg(1'b0, 1'b0);
        exp_en(0, c + 1);
        exp_en(1, c + 3);
        exp_en(2, c + 5);
        exp_en(3, c + 21);
        exp_en(4, c + 23);
        exp_st(c + 21, F_ERROR, 0, "expiry_tie_no_error");
        exp_st(c + 25, F_INSTRET, 1, "expiry_tie_instret");
        exp_st(c + 25, F_CYCLES, 24, "expiry_tie_cycles");
        exp_st(c + 27, F_ENQ, 0, "scoreboard_drained_c");
        wait_cyc(c + 10);
        run = 1'b0;
        wait_cyc(c + 28);
        dly[2] = 1;

        // Exec never completes: watchdog error after 16 WAIT cycles.
        do_reset();
        dly[2] = 0;
        c = cyc;
        run = 1'b1;
        push_cfg(1'b0, 1'b0);
        exp_en(0, c + 1);
        exp_en(1, c + 3);
        exp_en(2, c + 5);
        exp_st(c + 20, F_ERROR, 0, "error_before_expiry");
        exp_st(c + 21, F_ERROR, 1, "error_on_expiry");
        exp_st(c + 21, F_ERRSTG, 2, "err_stage_exec");
        exp_st(c + 21, F_CYCLES, 20, "error_cycles");
        exp_st(c + 35, F_ERROR, 1, "error_sticky");
        exp_st(c + 35, F_INSTRET, 0, "error_instret");
        exp_st(c + 35, F_ENQ, 0, "scoreboard_drained_d");
        wait_cyc(c + 36);
        dly[2] = 1;

        // Reset asserted in the cycle mem_done arrives, then restart from fetch.
        do_reset();
        c = cyc;
        run = 1'b1;
        push_cfg(1'b0, 1'b0);
        exp_en(0, c + 1);
        exp_en(1, c + 3);
        exp_en(2, c + 5);
        exp_en(3, c + 7);
        exp_st(c + 9, F_INSTRET, 0, "midreset_instret");
        exp_st(c + 9, F_CYCLES, 0, "midreset_cycles");
        exp_st(c + 9, F_ENABLES, 0, "midreset_enables");
        exp_st(c + 9, F_ERROR, 0, "midreset_error");
        wait_cyc(c + 8);
        rstn = 1'b0;
        wait_cyc(c + 10);
        rstn = 1'b1;
        push_cfg(1'b0, 1'b0);
        push_instr(c + 11, 1'b0);
        exp_st(c + 21, F_INSTRET, 1, "restart_instret");
        exp_st(c + 24, F_ENQ, 0, "scoreboard_drained_e");
        wait_cyc(c + 12);
        run = 1'b0;
        wait_cyc(c + 26);

        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
